// File: rtl/color_mean_feeder.sv
// Streaming per-channel RGB mean: accumulates a pixel group, then walks the three
// channel sums through one shared external rounding divider and presents the mean triple.
`ifndef SIZE_INT
`define SIZE_INT 32
`endif

module color_mean_feeder #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SUM_W     = `SIZE_INT,
  parameter int unsigned MAX_COUNT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  // Pixel stream
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_g,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  // Shared divider
  output logic [SUM_W-1:0]  div_dividend,
  output logic [SUM_W-1:0]  div_divisor,
  input  logic [SUM_W-1:0]  div_q,
  // Mean triple stream
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_g,
  output logic [DATA_W-1:0] out_b,
  output logic [SUM_W-1:0]  out_count
);

  typedef enum logic [2:0] {StAccum, StDivR, StDivG, StDivB, StOut} state_e;

  localparam logic [SUM_W-1:0] MaxQ     = SUM_W'({DATA_W{1'b1}});
  localparam logic [SUM_W-1:0] CountCap = SUM_W'(MAX_COUNT);
  localparam logic [SUM_W-1:0] One      = SUM_W'(1);

  state_e            state_q;
  logic [SUM_W-1:0]  sum_r_q, sum_g_q, sum_b_q, count_q;
  logic [DATA_W-1:0] res_r_q, res_g_q, res_b_q;
  logic [SUM_W-1:0]  res_count_q;

  logic              accept;
  logic [SUM_W-1:0]  count_inc;
  logic [DATA_W-1:0] q_sat;

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StOut);
  assign accept    = in_valid & in_ready;
  assign count_inc = count_q + One;

  assign out_r     = res_r_q;
  assign out_g     = res_g_q;
  assign out_b     = res_b_q;
  assign out_count = res_count_q;

  // Outside the DIV states the divider sees 0/1 so it never divides by zero.
  always_comb begin
    div_dividend = '0;
    div_divisor  = One;
    unique case (state_q)
      StDivR: begin
        div_dividend = sum_r_q;
        div_divisor  = count_q;
      end
      StDivG: begin
        div_dividend = sum_g_q;
        div_divisor  = count_q;
      end
      StDivB: begin
        div_dividend = sum_b_q;
        div_divisor  = count_q;
      end
      default: ;
    endcase
  end

  // Defensive clamp; a mean of DATA_W-bit samples cannot exceed the channel range.
  assign q_sat = (div_q > MaxQ) ? {DATA_W{1'b1}} : div_q[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAccum;
      sum_r_q     <= '0;
      sum_g_q     <= '0;
      sum_b_q     <= '0;
      count_q     <= '0;
      res_r_q     <= '0;
      res_g_q     <= '0;
      res_b_q     <= '0;
      res_count_q <= '0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (accept) begin
            sum_r_q <= sum_r_q + SUM_W'(in_r);
            sum_g_q <= sum_g_q + SUM_W'(in_g);
            sum_b_q <= sum_b_q + SUM_W'(in_b);
            count_q <= count_inc;
            if (in_last || (count_inc == CountCap)) begin
              state_q <= StDivR;
            end
          end
        end
        StDivR: begin
          res_r_q <= q_sat;
          state_q <= StDivG;
        end
        StDivG: begin
          res_g_q <= q_sat;
          state_q <= StDivB;
        end
        StDivB: begin
          res_b_q     <= q_sat;
          res_count_q <= count_q;
          state_q     <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            sum_r_q <= '0;
            sum_g_q <= '0;
            sum_b_q <= '0;
            count_q <= '0;
            state_q <= StAccum;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

endmodule

// File: tb/tb_color_mean_feeder.sv
// Directed bench for color_mean_feeder with a behavioural rounding divider attached.
`timescale 1ns/1ps

module tb_color_mean_feeder;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SUM_W  = 32;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_r, in_g, in_b;
  logic              in_last;
  logic [SUM_W-1:0]  div_dividend, div_divisor, div_q;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_r, out_g, out_b;
  logic [SUM_W-1:0]  out_count;

  int tests = 0;
  int fails = 0;
  bit div_zero_seen = 1'b0;

  color_mean_feeder #(
    .DATA_W   (DATA_W),
    .SUM_W    (SUM_W),
    .MAX_COUNT(256)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_r        (in_r),
    .in_g        (in_g),
    .in_b        (in_b),
    .in_last     (in_last),
    .div_dividend(div_dividend),
    .div_divisor (div_divisor),
    .div_q       (div_q),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_r       (out_r),
    .out_g       (out_g),
    .out_b       (out_b),
    .out_count   (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rounding divider: round up when remainder*2 >= divisor.
  always_comb begin
    if (div_divisor == '0) begin
      div_q = '0;
    end else begin
      div_q = div_dividend / div_divisor;
      if (((div_dividend % div_divisor) << 1) >= div_divisor) div_q = div_q + 1;
    end
  end

  always @(posedge clk) if (rst_n && div_divisor == '0) div_zero_seen <= 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel and wait (bounded) for it to be accepted; returns 1 cycle after the accept edge.
  task automatic push(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_r = r;
    in_g = g;
    in_b = b;
    in_last = last;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("out_valid_wait", 32'(out_valid), 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_valid_drop", 32'(out_valid), 32'd0);
    check("hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_triple(input string tag, input int r, input int g, input int b,
                              input int cnt);
    check({tag, "_r"}, 32'(out_r), 32'(r));
    check({tag, "_g"}, 32'(out_g), 32'(g));
    check({tag, "_b"}, 32'(out_b), 32'(b));
    check({tag, "_cnt"}, out_count, 32'(cnt));
  endtask

  initial begin
    logic [7:0] hold_r;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_r = '0;
    in_g = '0;
    in_b = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_divisor", div_divisor, 32'd1);
    check("rst_dividend", div_dividend, 32'd0);
    check("rst_out_r", 32'(out_r), 32'd0);
    check("rst_out_count", out_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Three-pixel group and 3-cycle latency
    push(8'd10, 8'd20, 8'd30, 1'b0);
    push(8'd20, 8'd30, 8'd40, 1'b0);
    push(8'd31, 8'd40, 8'd50, 1'b1);
    check("divr_in_ready", 32'(in_ready), 32'd0);
    check("divr_dividend", div_dividend, 32'd61);
    check("divr_divisor", div_divisor, 32'd3);
    check("lat_e1", 32'(out_valid), 32'd0);
    tick();
    check("divg_dividend", div_dividend, 32'd90);
    check("lat_e2", 32'(out_valid), 32'd0);
    tick();
    check("divb_dividend", div_dividend, 32'd120);
    check("lat_e3_pre", 32'(out_valid), 32'd0);
    tick();
    check("lat_e3", 32'(out_valid), 32'd1);
    check_triple("grp3", 20, 30, 40, 3);
    handshake();
    check("hold_after_hs_r", 32'(out_r), 32'd20);
    check("hold_after_hs_cnt", out_count, 32'd3);

    // Rounding 3/2 -> 2, plus backpressure
    push(8'd1, 8'd0, 8'd0, 1'b0);
    push(8'd2, 8'd0, 8'd0, 1'b1);
    wait_out();
    check_triple("round_up", 2, 0, 0, 2);
    hold_r = out_r;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_stable_r", 32'(out_r), 32'(hold_r));
    end
    check("bp_stable_cnt", out_count, 32'd2);
    handshake();

    // Rounding 4/3 -> 1, from a cleared sum
    push(8'd1, 8'd0, 8'd0, 1'b0);
    push(8'd1, 8'd0, 8'd0, 1'b0);
    push(8'd2, 8'd0, 8'd0, 1'b1);
    wait_out();
    check_triple("round_down", 1, 0, 0, 3);
    handshake();

    // Single pixel
    check("accum_divisor", div_divisor, 32'd1);
    check("accum_dividend", div_dividend, 32'd0);
    push(8'd7, 8'd8, 8'd9, 1'b1);
    wait_out();
    check_triple("single", 7, 8, 9, 1);
    handshake();

    // Forced close at MAX_COUNT with in_last never asserted
    for (int i = 0; i < 256; i++) push(8'd255, 8'd0, 8'd128, 1'b0);
    check("force_in_ready", 32'(in_ready), 32'd0);
    check("force_divisor", div_divisor, 32'd256);
    in_valid = 1'b1;
    in_r = 8'd1;
    in_g = 8'd1;
    in_b = 8'd1;
    wait_out();
    check_triple("force", 255, 0, 128, 256);
    tick();
    check("force_no_accept", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    handshake();

    // Async reset while in DIV_G discards the partial group
    push(8'd9, 8'd9, 8'd9, 1'b0);
    push(8'd3, 8'd3, 8'd3, 1'b1);
    tick();
    check("pre_abort_dividend", div_dividend, 32'd12);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_dividend", div_dividend, 32'd0);
    check("abort_divisor", div_divisor, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push(8'd4, 8'd4, 8'd4, 1'b0);
    push(8'd6, 8'd6, 8'd6, 1'b1);
    check("post_abort_dividend", div_dividend, 32'd10);
    wait_out();
    check_triple("post_abort", 5, 5, 5, 2);
    handshake();

    check("no_zero_divisor", 32'(div_zero_seen), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/color_mean_feeder.md
# color_mean_feeder

Streaming per-channel mean stage that wraps the combinational rounding `Divider`. It accepts RGB pixels over a valid/ready stream and accumulates channel sums and a pixel count until the group closes. It then sequences the three channel sums through one shared `Divider` instance, one cycle per channel, and presents the rounded mean RGB triple on an output valid/ready port. Directly upstream it feeds the divider's `Dividend`/`Divisor`; directly downstream it consumes the divider's `Q`.

## Interface
- `DATA_W`, default 8: channel width.
- `SUM_W`, default `` `size_int ``: accumulator width; must match the divider width. Requires `SUM_W >= DATA_W + clog2(MAX_COUNT)`.
- `MAX_COUNT`, default 256: maximum number of pixels per group.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `in_valid`  in  1  pixel valid.
- `in_ready`  out  1  pixel accepted on the edge where `in_valid & in_ready`.
- `in_r`, `in_g`, `in_b`  in  DATA_W each  pixel channels.
- `in_last`  in  1  the accepted pixel closes the group.
- `div_dividend`  out  SUM_W  to `Divider.Dividend`.
- `div_divisor`  out  SUM_W  to `Divider.Divisor`.
- `div_q`  in  SUM_W  from `Divider.Q` (rounded quotient, combinational).
- `out_valid`  out  1  mean triple valid.
- `out_ready`  in  1  consumer accepts the triple.
- `out_r`, `out_g`, `out_b`  out  DATA_W each  rounded means.
- `out_count`  out  SUM_W  number of pixels in the group.

## Operation
- States: ACCUM, DIV_R, DIV_G, DIV_B, OUT. Reset state is ACCUM.
- Reset values: `sum_r`, `sum_g`, `sum_b` and `count` are 0. All outputs are 0 except `in_ready=1` and `div_divisor=1`.
- ACCUM:
  - `in_ready=1`.
  - On an accept: each `sum_x += in_x` (zero-extended), and `count += 1`.
  - If `in_last`, or the incremented count equals MAX_COUNT, go to DIV_R. The forced close at MAX_COUNT behaves exactly like `in_last`.
- DIV_R / DIV_G / DIV_B:
  - `in_ready=0`.
  - `div_dividend = sum_x` for the current channel; `div_divisor = count`.
  - At the clock edge, register `div_q` into the channel's result register and advance one state. DIV_B advances to OUT.
- Saturation: a captured quotient greater than 2^DATA_W−1 is clamped to 2^DATA_W−1. Arithmetic keeps this from happening; the clamp is defensive.
- Divisor in non-DIV states: `div_divisor=1` and `div_dividend=0`, so the divider never sees a zero divisor. `count` is always ≥1 in DIV states.
- OUT:
  - `out_valid=1`. `out_r/g/b` and `out_count` are held stable while `out_ready=0`.
  - On `out_valid & out_ready`: clear sums and count, and return to ACCUM.
  - `out_r/g/b` and `out_count` keep their last values after the handshake; only `out_valid` drops.
- Input during DIV/OUT is not accepted (`in_ready=0`); the upstream must hold it.
- Rounding comes from the divider: the quotient rounds up when remainder·2 ≥ divisor.
- Reset mid-operation, in any state: immediately return to ACCUM with sums and count zeroed and `out_valid=0`. A partial group is discarded.

## Timing
- Edge E0 accepts the closing pixel; that pixel is included in the sums.
- The R, G and B quotients are captured at edges E1, E2 and E3.
- `out_valid` rises after E3, giving 3 cycles of latency from the last accept to valid output.
- `in_ready` rises in the cycle after the output-handshake edge.
- Back-to-back throughput: one group per (N + 4) cycles for a group of N pixels when `out_ready=1` is held.
- The combinational divider path (`div_dividend` → `div_q` → capture register) must close within one clock period. `div_dividend` and `div_divisor` are driven from registers and the state decode only.

## Test plan
- Three pixels (10,20,30), (20,30,40), (31,40,50) with `in_last` on the third → `out_r=20` (61/3=20.33), `out_g=30`, `out_b=40`, `out_count=3`; `out_valid` rises 3 cycles after the third accept.
- Rounding: pixels R=1 and R=2 (sum 3, count 2) → `out_r=2` (1.5 rounds up). R=1,1,2 (4/3) → `out_r=1`.
- Forced close: 256 pixels of (255,0,128) with `in_last` never asserted → group closes on the 256th accept; output is (255,0,128) with `out_count=256`; no 257th accept occurs until the output handshake.
- Backpressure: hold `out_ready=0` for 10 cycles → triple stays stable, `in_ready=0` throughout. Set `out_ready=1` → handshake, `in_ready=1` on the next cycle, next group accumulates from a zero sum.
- Single pixel (7,8,9) with `in_last` → output (7,8,9), `out_count=1`. During ACCUM, `div_divisor` reads 1.
- Assert `rst_n=0` asynchronously while in DIV_G → `out_valid=0`, `in_ready=1` and sums zero immediately. A subsequent group of (4,4,4),(6,6,6) → (5,5,5) with no residue from the aborted group.
